// File: rtl/shot_tracker.sv
// rtl/shot_tracker.sv - shot entry and hit-map generator for player 2
//
// Snapshots player 1's 5x7 board on start, takes (column,line) shots on rising
// edges of fire, and builds the hit map shown by the matrix display. Counts
// shots left and hits and declares win or loss.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 pulse: snapshot board and (re)start the game
//   board_col1..5 [6:0]   player 1 board, bit n = line n, 1 = ship cell
//   sel_col [2:0]         shot column, valid 1..5
//   sel_line [2:0]        shot line, valid 0..6
//   fire                  debounced fire button level
//   colHit1..5 [6:0]      hit map, bit n = line n hit
//   shots_left [7:0]      remaining shots
//   hits [5:0]            ship cells hit so far
//   shot_done             1-cycle pulse when a shot is resolved
//   shot_hit, shot_err    qualified by shot_done
//   result [1:0]          00 playing/idle, 01 won, 10 lost
//
// Build option: REPEAT_SHOT_FREE_EN makes a shot at an already-fired cell an
// error that consumes nothing; otherwise it silently burns one shot.
module shot_tracker #(
  parameter int MAX_SHOTS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] board_col1,
  input  logic [6:0] board_col2,
  input  logic [6:0] board_col3,
  input  logic [6:0] board_col4,
  input  logic [6:0] board_col5,
  input  logic [2:0] sel_col,
  input  logic [2:0] sel_line,
  input  logic       fire,
  output logic [6:0] colHit1,
  output logic [6:0] colHit2,
  output logic [6:0] colHit3,
  output logic [6:0] colHit4,
  output logic [6:0] colHit5,
  output logic [7:0] shots_left,
  output logic [5:0] hits,
  output logic       shot_done,
  output logic       shot_hit,
  output logic       shot_err,
  output logic [1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_CHECK, S_DONE} state_t;

  state_t      state, state_n;
  logic        fire_q;
  logic        rise;
  // Cell (col c, line n) lives at bit c*7+n of each flat 35-bit map.
  logic [34:0] board_q, fired_q, hit_q;
  logic [5:0]  ship_cells;
  logic [2:0]  lat_col, lat_line;

  logic        do_load, do_latch, do_resolve;
  logic [5:0]  pop;
  logic        bad, already, is_ship, counted, reject, new_hit, win, loss;
  logic [2:0]  c;
  logic [5:0]  idx;
  logic [5:0]  hits_nx;
  logic [7:0]  left_nx;

  assign rise = fire & ~fire_q;
  assign pop  = 6'($countones(board_q));

  // Shot resolution for the latched coordinates.
  always_comb begin
    bad     = (lat_col == 3'd0) || (lat_col > 3'd5) || (lat_line == 3'd7);
    c       = lat_col - 3'd1;
    // Out-of-range shots are rejected anyway; park the index on a legal bit.
    idx     = bad ? 6'd0 : ({3'b000, c} * 6'd7 + {3'b000, lat_line});
    already = fired_q[idx];
    is_ship = board_q[idx];
`ifdef REPEAT_SHOT_FREE_EN
    counted = !bad && !already;
    reject  = bad || already;
`else
    counted = !bad;
    reject  = bad;
`endif
    new_hit = counted && !already && is_ship;
    hits_nx = hits + {5'd0, new_hit};
    left_nx = shots_left - {7'd0, counted};
    // A win on the very last shot beats the out-of-shots loss.
    win     = counted && (hits_nx == ship_cells);
    loss    = counted && !win && (left_nx == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_load    = 1'b0;
    do_latch   = 1'b0;
    do_resolve = 1'b0;
    case (state)
      S_IDLE:  state_n = S_IDLE;
      S_LOAD:  state_n = (pop == 6'd0) ? S_DONE : S_ARMED;
      S_ARMED: begin
        if (rise) begin
          do_latch = 1'b1;
          state_n  = S_CHECK;
        end
      end
      S_CHECK: begin
        do_resolve = 1'b1;
        state_n    = (win || loss) ? S_DONE : S_ARMED;
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
    // start restarts the game from anywhere, even mid-shot.
    if (start) begin
      state_n    = S_LOAD;
      do_load    = 1'b1;
      do_latch   = 1'b0;
      do_resolve = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_q     <= 1'b0;
      board_q    <= '0;
      fired_q    <= '0;
      hit_q      <= '0;
      ship_cells <= '0;
      lat_col    <= '0;
      lat_line   <= '0;
      shots_left <= '0;
      hits       <= '0;
      shot_done  <= 1'b0;
      shot_hit   <= 1'b0;
      shot_err   <= 1'b0;
      result     <= 2'b00;
    end else begin
      fire_q    <= fire;
      shot_done <= 1'b0;
      shot_hit  <= 1'b0;
      shot_err  <= 1'b0;
      if (do_load) begin
        board_q    <= {board_col5, board_col4, board_col3, board_col2, board_col1};
        fired_q    <= '0;
        hit_q      <= '0;
        hits       <= '0;
        shots_left <= 8'(MAX_SHOTS);
        result     <= 2'b00;
      end
      if (state == S_LOAD && !start) begin
        ship_cells <= pop;
        if (pop == 6'd0) result <= 2'b01;
      end
      if (do_latch) begin
        lat_col  <= sel_col;
        lat_line <= sel_line;
      end
      if (do_resolve) begin
        shot_done <= 1'b1;
        shot_err  <= reject;
        shot_hit  <= new_hit;
        if (counted) begin
          fired_q[idx] <= 1'b1;
          shots_left   <= left_nx;
          hits         <= hits_nx;
          if (new_hit) hit_q[idx] <= 1'b1;
          if (win)       result <= 2'b01;
          else if (loss) result <= 2'b10;
        end
      end
    end
  end

  assign colHit1 = hit_q[6:0];
  assign colHit2 = hit_q[13:7];
  assign colHit3 = hit_q[20:14];
  assign colHit4 = hit_q[27:21];
  assign colHit5 = hit_q[34:28];

endmodule

// File: tb/tb_shot_tracker.sv
// tb/tb_shot_tracker.sv - self-checking bench for shot_tracker
module tb_shot_tracker;

  logic       clk = 1'b0;
  logic       rst_n, start, fire;
  logic [6:0] bcol [5];
  logic [2:0] sel_col, sel_line;
  logic [6:0] colHit1, colHit2, colHit3, colHit4, colHit5;
  logic [7:0] shots_left;
  logic [5:0] hits;
  logic       shot_done, shot_hit, shot_err;
  logic [1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain game rules on 2-D arrays.
  bit m_board [5][7];
  bit m_fired [5][7];
  bit m_hit   [5][7];
  int m_left, m_hits, m_ships, m_res;
  bit m_armed;

  always #5 clk = ~clk;

  shot_tracker #(.MAX_SHOTS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .board_col1(bcol[0]), .board_col2(bcol[1]), .board_col3(bcol[2]),
    .board_col4(bcol[3]), .board_col5(bcol[4]),
    .sel_col(sel_col), .sel_line(sel_line), .fire(fire),
    .colHit1(colHit1), .colHit2(colHit2), .colHit3(colHit3),
    .colHit4(colHit4), .colHit5(colHit5),
    .shots_left(shots_left), .hits(hits),
    .shot_done(shot_done), .shot_hit(shot_hit), .shot_err(shot_err),
    .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] mcol(input int c);
    logic [6:0] v;
    for (int n = 0; n < 7; n++) v[n] = m_hit[c][n];
    return v;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".shots_left"}, shots_left, m_left);
    chk({tag, ".hits"}, hits, m_hits);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".colHit1"}, colHit1, mcol(0));
    chk({tag, ".colHit2"}, colHit2, mcol(1));
    chk({tag, ".colHit3"}, colHit3, mcol(2));
    chk({tag, ".colHit4"}, colHit4, mcol(3));
    chk({tag, ".colHit5"}, colHit5, mcol(4));
  endtask

  task automatic model_clear();
    for (int c = 0; c < 5; c++)
      for (int n = 0; n < 7; n++) begin
        m_fired[c][n] = 0;
        m_hit[c][n]   = 0;
      end
    m_hits = 0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int c = 0; c < 5; c++)
      for (int n = 0; n < 7; n++) m_board[c][n] = 0;
    m_left = 0; m_ships = 0; m_res = 0; m_armed = 0;
  endtask

  task automatic model_shot(input int c, input int l, output bit ed, output bit eh, output bit ee);
    ed = 0; eh = 0; ee = 0;
    if (!m_armed) return;
    ed = 1;
    if (c < 1 || c > 5 || l > 6) begin
      ee = 1;
      return;
    end
    if (m_fired[c-1][l]) begin
`ifdef REPEAT_SHOT_FREE_EN
      ee = 1;
      return;
`else
      m_left--;
`endif
    end else begin
      m_fired[c-1][l] = 1;
      m_left--;
      if (m_board[c-1][l]) begin
        m_hit[c-1][l] = 1;
        m_hits++;
        eh = 1;
      end
    end
    if (m_hits == m_ships) begin
      m_res = 1; m_armed = 0;
    end else if (m_left == 0) begin
      m_res = 2; m_armed = 0;
    end
  endtask

  task automatic do_start(input logic [6:0] b0, input logic [6:0] b1, input logic [6:0] b2,
                          input logic [6:0] b3, input logic [6:0] b4, input string tag);
    logic [6:0] b [5];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) bcol[c] = b[c];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_clear();
    m_ships = 0;
    for (int c = 0; c < 5; c++)
      for (int n = 0; n < 7; n++) begin
        m_board[c][n] = b[c][n];
        m_ships += b[c][n];
      end
    m_left = 10;
    m_res   = (m_ships == 0) ? 1 : 0;
    m_armed = (m_ships != 0);
    @(posedge clk); #1;
    check_state(tag);
  endtask

  // Fire rises just after edge N; the shot resolves at edge N+2.
  task automatic do_shot(input int c, input int l, input string tag);
    bit ed, eh, ee;
    model_shot(c, l, ed, eh, ee);
    @(posedge clk); #1;
    sel_col = 3'(c); sel_line = 3'(l); fire = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".early_done"}, shot_done, 0);
    fire = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".done"}, shot_done, ed);
    chk({tag, ".hit"}, shot_hit, eh);
    chk({tag, ".err"}, shot_err, ee);
    check_state(tag);
    @(posedge clk); #1;
    chk({tag, ".done_cleared"}, shot_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fire = 1'b0; sel_col = '0; sel_line = '0;
    for (int c = 0; c < 5; c++) bcol[c] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset.done", shot_done, 0);
    check_state("reset");
    do_shot(2, 1, "idle_shot");

    // Single 2-cell ship in column 2, sunk in two shots.
    do_start(7'h00, 7'b0000110, 7'h00, 7'h00, 7'h00, "t2.start");
    do_shot(2, 1, "t2.hit");
    do_shot(2, 2, "t3.win");
    do_shot(3, 3, "t3.after_win");

    // Fire held across start must not count until released and pressed again.
    @(posedge clk); #1 fire = 1'b1;
    do_start(7'h01, 7'h00, 7'h00, 7'h00, 7'h00, "t8.start");
    repeat (3) begin
      @(posedge clk); #1;
      chk("t8.held_no_done", shot_done, 0);
    end
    check_state("t8.held");
    fire = 1'b0;
    do_shot(4, 4, "t8.fresh");

    // Illegal coordinates and repeated cells.
    do_start(7'h01, 7'h00, 7'h00, 7'h00, 7'h00, "t5.start");
    do_shot(0, 3, "t5.col0");
    do_shot(6, 0, "t5.col6");
    do_shot(1, 7, "t5.line7");
    do_shot(3, 3, "t6.first");
    do_shot(3, 3, "t6.repeat");

    // Ten misses drain the magazine and lose.
    do_start(7'h01, 7'h00, 7'h00, 7'h00, 7'h00, "t4.start");
    for (int i = 0; i < 10; i++) do_shot(2 + i / 7, i % 7, $sformatf("t4.miss%0d", i));
    chk("t4.lost", result, 2);

    do_start(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, "t7.empty");

    // Random games, sparse boards, mostly legal shots; restarts may hit mid-game.
    for (int g = 0; g < 8; g++) begin
      logic [6:0] rb [5];
      for (int c = 0; c < 5; c++)
        for (int n = 0; n < 7; n++) rb[c][n] = ($urandom_range(0, 99) < 8);
      do_start(rb[0], rb[1], rb[2], rb[3], rb[4], $sformatf("rnd%0d.start", g));
      for (int s = 0; s < 14; s++) begin
        int rc, rl;
        if ($urandom_range(0, 9) < 8) begin
          rc = $urandom_range(1, 5); rl = $urandom_range(0, 6);
        end else begin
          rc = $urandom_range(0, 7); rl = $urandom_range(0, 7);
        end
        do_shot(rc, rl, $sformatf("rnd%0d.s%0d", g, s));
      end
    end

    // Reset in the middle of a game.
    do_start(7'h7f, 7'h00, 7'h00, 7'h00, 7'h00, "t1.start");
    do_shot(1, 0, "t1.pre");
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    check_state("t1.after_reset");
    do_shot(1, 1, "t1.ignored");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
